// File: rtl/reg_file_param.sv
// Parameterised two-read/one-write register file with an instruction-field decoder,
// immediate extender and a soft-clear sweep that zeroes one register per cycle.
`timescale 1ns/1ps

module reg_file_param #(
    parameter int WIDTH    = 32,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [1:0]       ext_mode,
    input  logic             clr,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic [31:0]      imm,
    output logic             busy,
    output logic             clr_done
);

    localparam int DEPTH = 1 << AW;

    if (AW < 1 || AW > 5) begin : g_aw_check
        $error("reg_file_param: AW must be in 1..5");
    end

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [AW-1:0]     ptr;
    logic [AW-1:0]     ra1;
    logic [AW-1:0]     ra2;
    logic [WIDTH-1:0]  regs [DEPTH];
    logic              wr_en;
    logic              fwd1;
    logic              fwd2;
    logic [15:0]       imm16;
    logic              unused_instr;

    assign ra1          = instr[21 +: AW];
    assign ra2          = instr[16 +: AW];
    assign imm16        = instr[15:0];
    assign unused_instr = ^instr[31:16];

    // A write is accepted outside the sweep, except the hard-wired zero register.
    assign wr_en = we && (state != SWEEP) && !(ZERO_REG && (wa == '0));
    assign fwd1  = BYPASS && wr_en && (wa == ra1);
    assign fwd2  = BYPASS && wr_en && (wa == ra2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (state == SWEEP) begin
            regs[ptr] <= '0;
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = regs[ra1];
        rd2 = regs[ra2];
        if (fwd1) begin
            rd1 = wd;
        end
        if (fwd2) begin
            rd2 = wd;
        end
        if (ZERO_REG && (ra1 == '0)) begin
            rd1 = '0;
        end
        if (ZERO_REG && (ra2 == '0)) begin
            rd2 = '0;
        end
    end

    always_comb begin
        imm = 32'h0;
        case (ext_mode)
            2'b00:   imm = {{16{imm16[15]}}, imm16};
            2'b01:   imm = {16'h0, imm16};
            2'b10:   imm = {imm16, 16'h0};
            default: imm = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (clr) next_state = SWEEP;
            SWEEP:   if (ptr == AW'(DEPTH - 1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == SWEEP);
        clr_done = (state == DONE);
    end

    // Pointer wraps back to zero after the last register, ready for the next sweep.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (state == SWEEP) begin
            ptr <= ptr + AW'(1);
        end else begin
            ptr <= '0;
        end
    end

endmodule
